// File: rtl/dfe_pkg.sv
// Shared types and helpers for the PAM4 decision-feedback equaliser:
// FSM state encoding, symbol type, symbol-to-level lookup and saturation.
package dfe_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    typedef logic [1:0] pam4_sym_t;

    // Symbol 0..3 maps to -3S/2, -S/2, +S/2, +3S/2.
    function automatic int level_of(input pam4_sym_t sym, input int sep);
        case (sym)
            2'd0:    return -(3 * sep) / 2;
            2'd1:    return -sep / 2;
            2'd2:    return sep / 2;
            default: return (3 * sep) / 2;
        endcase
    endfunction

    function automatic longint sat(input longint v, input int w);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -hi - 1;
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage

// File: rtl/dfe_pam4_adapt_slicer.sv
// Combinational PAM4 slicer: equalised estimate to symbol and ideal level.
// A value sitting exactly on a threshold resolves to the upper symbol.
module pam4_slicer
    import dfe_pkg::*;
#(
    parameter int DW      = 8,
    parameter int SYM_SEP = 56
) (
    input  logic signed [DW-1:0] est,
    output pam4_sym_t            sym,
    output logic signed [DW-1:0] level
);

    localparam logic signed [DW-1:0] THR  = DW'(SYM_SEP);
    localparam logic signed [DW-1:0] ZERO = DW'(0);

    always_comb begin
        if (est >= THR)
            sym = 2'd3;
        else if (est >= ZERO)
            sym = 2'd2;
        else if (est >= -THR)
            sym = 2'd1;
        else
            sym = 2'd0;
        level = DW'(level_of(sym, SYM_SEP));
    end

endmodule

// File: rtl/dfe_pam4_adapt.sv
// PAM4 decision-feedback equaliser with configurable taps and single-cycle feedback.
// Define DFE_SSLMS_ADAPT_EN to enable sign-sign LMS adaptation of the post-cursor taps.
module dfe_pam4_adapt
    import dfe_pkg::*;
#(
    parameter int N_TAPS  = 5,
    parameter int DW      = 8,
    parameter int CW      = 16,
    parameter int FRAC    = 8,
    parameter int SYM_SEP = 56
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] in_data,
    output logic                 in_ready,
    input  logic                 cfg_valid,
    input  logic [3:0]           cfg_addr,
    input  logic [CW-1:0]        cfg_data,
    output logic                 cfg_ready,
    input  logic                 flush,
    output logic                 out_valid,
    output logic [1:0]           out_sym,
    output logic signed [DW-1:0] out_level,
    output logic signed [DW-1:0] out_est,
    output logic signed [DW-1:0] out_err,
    output logic                 cfg_err,
    output logic [15:0]          drop_cnt,
    output logic [1:0]           state
);

    // Product, ISI sum, accumulator and gain-stage widths; each is wide enough for its worst case.
    localparam int PW = CW + DW;
    localparam int SW = PW + $clog2(N_TAPS);
    localparam int XW = DW + FRAC;
    localparam int AW = ((SW > XW) ? SW : XW) + 1;
    localparam int MW = AW + CW;
    localparam int EW = DW + 1;

    state_t                state_q, state_nxt;
    logic [N_TAPS-1:0]     mask, mask_nxt;
    logic signed [CW-1:0]  coef     [N_TAPS];
    logic signed [CW-1:0]  coef_nxt [N_TAPS];
    logic signed [DW-1:0]  hist     [N_TAPS-1];
    logic signed [DW-1:0]  hist_eff [N_TAPS-1];
    logic signed [SW-1:0]  isi;
    logic signed [AW-1:0]  acc;
    logic signed [MW-1:0]  prod, est_sh;
    logic signed [DW-1:0]  est, level, err;
    logic signed [EW-1:0]  err_full;
    pam4_sym_t             sym;
    logic                  accept, cfg_hit;

    assign in_ready  = (state_q == RUN);
    assign cfg_ready = 1'b1;
    assign state     = state_q;
    assign accept    = in_valid && (state_q == RUN);
    assign cfg_hit   = cfg_valid && (int'(cfg_addr) < N_TAPS);

    // A flush in the same cycle as a sample must hide the old history from that sample.
    always_comb begin
        for (int j = 0; j < N_TAPS - 1; j++)
            hist_eff[j] = flush ? '0 : hist[j];
    end

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        isi = '0;
        for (int k = 1; k < N_TAPS; k++)
            isi = isi + SW'(coef[k]) * SW'(hist_eff[k-1]);
        acc      = (AW'(in_data) <<< FRAC) - AW'(isi);
        prod     = MW'(acc) * MW'(coef[0]);
        est_sh   = prod >>> (2 * FRAC);
        est      = DW'(sat(longint'(est_sh), DW));
        err_full = EW'(est) - EW'(level);
        err      = DW'(sat(longint'(err_full), DW));
    end

    pam4_slicer #(.DW(DW), .SYM_SEP(SYM_SEP)) u_slicer (
        .est   (est),
        .sym   (sym),
        .level (level)
    );

    always_comb begin
        coef_nxt = coef;
        mask_nxt = mask;
`ifdef DFE_SSLMS_ADAPT_EN
        if (accept) begin
            for (int k = 1; k < N_TAPS; k++) begin
                if (err != '0 && hist_eff[k-1] != '0)
                    coef_nxt[k] = CW'(sat(longint'(coef[k]) +
                                  ((err[DW-1] ^ hist_eff[k-1][DW-1]) ? -64'sd1 : 64'sd1), CW));
            end
        end
`endif
        // A host write lands after adaptation so it overrides the update to the same tap.
        for (int k = 0; k < N_TAPS; k++) begin
            if (cfg_hit && cfg_addr == 4'(k)) begin
                coef_nxt[k] = cfg_data;
                mask_nxt[k] = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (cfg_hit) state_nxt = LOAD;
            LOAD:    if (&mask_nxt) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            mask      <= '0;
            // NOTE: coefficient and history arrays are plain flops and are reset like any other state.
            for (int k = 0; k < N_TAPS; k++)
                coef[k] <= '0;
            for (int j = 0; j < N_TAPS - 1; j++)
                hist[j] <= '0;
            drop_cnt  <= '0;
            cfg_err   <= 1'b0;
            out_valid <= 1'b0;
            out_sym   <= '0;
            out_level <= '0;
            out_est   <= '0;
            out_err   <= '0;
        end else begin
            state_q   <= state_nxt;
            mask      <= mask_nxt;
            coef      <= coef_nxt;
            out_valid <= accept;
            if (cfg_valid && !cfg_hit)
                cfg_err <= 1'b1;
            if (in_valid && state_q != RUN && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
            if (accept) begin
                hist[0] <= level;
                for (int j = 1; j < N_TAPS - 1; j++)
                    hist[j] <= hist_eff[j-1];
                out_sym   <= sym;
                out_level <= level;
                out_est   <= est;
                out_err   <= err;
            end else if (flush) begin
                for (int j = 0; j < N_TAPS - 1; j++)
                    hist[j] <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dfe_pam4_adapt.sv
// Directed self-checking bench for dfe_pam4_adapt: vector table plus hand-written
// sequences for drop counting, ISI feedback, flush, config errors and reset abort.
module tb_dfe_pam4_adapt;

    logic              clk;
    logic              rstn;
    logic              in_valid;
    logic signed [7:0] in_data;
    logic              in_ready;
    logic              cfg_valid;
    logic [3:0]        cfg_addr;
    logic [15:0]       cfg_data;
    logic              cfg_ready;
    logic              flush;
    logic              out_valid;
    logic [1:0]        out_sym;
    logic signed [7:0] out_level;
    logic signed [7:0] out_est;
    logic signed [7:0] out_err;
    logic              cfg_err;
    logic [15:0]       drop_cnt;
    logic [1:0]        state;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int din;
        int sym;
        int level;
        int est;
        int err;
    } vec_t;

    vec_t vecs [10];

    dfe_pam4_adapt dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .cfg_valid (cfg_valid),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_ready (cfg_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_sym   (out_sym),
        .out_level (out_level),
        .out_est   (out_est),
        .out_err   (out_err),
        .cfg_err   (cfg_err),
        .drop_cnt  (drop_cnt),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic check_out(input string name, input int sym, input int level,
                             input int est, input int err);
        check({name, " valid"}, int'(out_valid), 1);
        check({name, " sym"},   int'(out_sym), sym);
        check({name, " level"}, int'(out_level), level);
        check({name, " est"},   int'(out_est), est);
        check({name, " err"},   int'(out_err), err);
    endtask

    task automatic cfg_write(input int addr, input int data);
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_addr  = 4'(addr);
        cfg_data  = 16'(data);
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    // One isolated sample; outputs are checked on the falling edge after acceptance.
    task automatic sample(input int din, input bit fl, input string name, input int sym,
                          input int level, input int est, input int err);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'(din);
        flush    = fl;
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        check_out(name, sym, level, est, err);
    endtask

    task automatic do_flush();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic configure(input int c0, input int c1);
        cfg_write(0, c0);
        cfg_write(1, c1);
        for (int k = 2; k < 5; k++)
            cfg_write(k, 0);
    endtask

    task automatic reset_dut();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        vecs[0] = '{din:  28,  sym: 2, level:  28, est:  28,  err:   0};
        vecs[1] = '{din: -28,  sym: 1, level: -28, est: -28,  err:   0};
        vecs[2] = '{din:  84,  sym: 3, level:  84, est:  84,  err:   0};
        vecs[3] = '{din: -84,  sym: 0, level: -84, est: -84,  err:   0};
        vecs[4] = '{din:  56,  sym: 3, level:  84, est:  56,  err: -28};
        vecs[5] = '{din:   0,  sym: 2, level:  28, est:   0,  err: -28};
        vecs[6] = '{din: -56,  sym: 1, level: -28, est: -56,  err: -28};
        vecs[7] = '{din: -57,  sym: 0, level: -84, est: -57,  err:  27};
        vecs[8] = '{din:  55,  sym: 2, level:  28, est:  55,  err:  27};
        vecs[9] = '{din: 127,  sym: 3, level:  84, est: 127,  err:  43};

        in_valid = 1'b0; in_data = '0; cfg_valid = 1'b0; cfg_addr = '0;
        cfg_data = '0;   flush = 1'b0; rstn = 1'b0;
        #23;
        check("reset state",    int'(state), 0);
        check("reset drop_cnt", int'(drop_cnt), 0);
        check("reset out_valid", int'(out_valid), 0);
        check("reset in_ready", int'(in_ready), 0);
        check("reset cfg_err",  int'(cfg_err), 0);
        check("cfg_ready",      int'(cfg_ready), 1);
        @(negedge clk);
        rstn = 1'b1;

`ifdef DFE_SSLMS_ADAPT_EN
        configure(256, 0);
        check("adapt state run", int'(state), 2);
        do_flush();
        sample(28, 1'b0, "adapt seed", 2, 28, 28, 0);
        check("adapt c1 unchanged on zero err", int'(dut.coef[1]), 0);
        sample(30, 1'b0, "adapt step", 2, 28, 30, 2);
        check("adapt c1 incremented", int'(dut.coef[1]), 1);
        check("adapt c2 zero history", int'(dut.coef[2]), 0);
        // c1=1 against decision 28: est floors to 29, err +1 would raise c1, but a write wins.
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'sd30;
        cfg_valid = 1'b1; cfg_addr = 4'd1; cfg_data = 16'd0;
        @(negedge clk);
        in_valid = 1'b0; cfg_valid = 1'b0;
        check_out("adapt vs cfg", 2, 28, 29, 1);
        check("cfg write beats adapt", int'(dut.coef[1]), 0);
`else
        // Samples offered before configuration are dropped and counted.
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'sd28;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle in_ready", int'(in_ready), 0);
            check("idle no out_valid", int'(out_valid), 0);
        end
        in_valid = 1'b0;
        check("drop_cnt after 3", int'(drop_cnt), 3);
        @(negedge clk);
        check("drop_cnt holds", int'(drop_cnt), 3);
        check("still idle", int'(state), 0);

        cfg_write(0, 256);
        check("state load", int'(state), 1);
        for (int k = 1; k < 4; k++)
            cfg_write(k, 0);
        check("load until mask full", int'(state), 1);
        cfg_write(4, 0);
        check("state run", int'(state), 2);
        check("run in_ready", int'(in_ready), 1);

        for (int i = 0; i < 10; i++)
            sample(vecs[i].din, 1'b0, $sformatf("vec%0d", i), vecs[i].sym,
                   vecs[i].level, vecs[i].est, vecs[i].err);
        @(negedge clk);
        check("out_valid single pulse", int'(out_valid), 0);

        // c1 = 0.25: back-to-back 28 then 35 gives 35 - 0.25*28 = 28.
        cfg_write(1, 64);
        do_flush();
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'sd28;
        @(negedge clk);
        in_data = 8'sd35;
        check_out("b2b first", 2, 28, 28, 0);
        @(negedge clk);
        in_valid = 1'b0;
        check_out("b2b second", 2, 28, 28, 0);

        // Write c1=0 together with a sample: that sample still sees c1=64.
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'sd35;
        cfg_valid = 1'b1; cfg_addr = 4'd1; cfg_data = 16'd0;
        @(negedge clk);
        in_valid = 1'b0; cfg_valid = 1'b0;
        check_out("cfg same cycle old coef", 2, 28, 28, 0);
        sample(35, 1'b0, "cfg applied next", 2, 28, 35, 7);
        cfg_write(1, 64);

        cfg_write(9, 1234);
        check("cfg_err set", int'(cfg_err), 1);
        check("bad addr state", int'(state), 2);
        sample(35, 1'b1, "flush coincident", 2, 28, 35, 7);
        sample(35, 1'b0, "isi after flush", 2, 28, 28, 0);
        do_flush();
        sample(35, 1'b0, "flush alone", 2, 28, 35, 7);
        sample(-84, 1'b0, "neg input", 0, -84, -91, -7);
        sample(0, 1'b0, "neg history isi", 2, 28, 21, -7);

        // c0 = 2.0 drives est past full scale.
        cfg_write(0, 512);
        do_flush();
        sample(100, 1'b0, "sat high", 3, 84, 127, 43);
        sample(-100, 1'b0, "sat low", 0, -84, -128, -44);

        // Reset with an output just registered.
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'sd28;
        @(posedge clk);
        #1;
        check("pending out_valid", int'(out_valid), 1);
        rstn = 1'b0; in_valid = 1'b0;
        #1;
        check("rst out_valid", int'(out_valid), 0);
        check("rst out_est",   int'(out_est), 0);
        check("rst out_sym",   int'(out_sym), 0);
        check("rst out_level", int'(out_level), 0);
        check("rst state",     int'(state), 0);
        check("rst drop_cnt",  int'(drop_cnt), 0);
        check("rst cfg_err",   int'(cfg_err), 0);
        @(negedge clk);
        rstn = 1'b1;

        // Reset asserted while a sample is being offered: it must never emerge.
        configure(256, 0);
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'sd84;
        #2;
        rstn = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        rstn = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("aborted no out_valid", int'(out_valid), 0);
        end
        check("abort state idle", int'(state), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
